// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared constants and fetch-state encoding for the MIPS IF stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_WAIT  = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/ifid_reg.sv
// ============================================================================
// Module : ifid_reg
// Brief  : IF/ID pipeline register with stall-hold and flush-to-NOP.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifid_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q,   pc4_d;
    logic        valid_q, valid_d;

    // Flush wins over everything, then a delivery, then stall-hold, else bubble.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end else if (!stall_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule : ifid_reg

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : MIPS IF stage: PC register, single-outstanding imem fetch, IF/ID load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Redirect,
    input  logic [31:0] NextPC,
    input  logic        Stall,
    input  logic        Imem_Ready,
    input  logic        Imem_RValid,
    input  logic [31:0] Imem_RData,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    output logic [31:0] PC_Out,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PC4,
    output logic        IFID_Valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc4_q, pend_pc4_d;
    logic [31:0]  buf_q, buf_d;
    logic         kill_q, kill_d;

    logic         deliver;
    logic [31:0]  deliver_instr;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = pc_q + PC_STEP;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc4_d    = pend_pc4_q;
        buf_d         = buf_q;
        kill_d        = kill_q;
        deliver       = 1'b0;
        deliver_instr = Imem_RData;

        if (Redirect) begin
            pc_d = {NextPC[31:2], 2'b00};
            unique case (state_q)
                ST_FETCH: state_d = ST_FETCH;
                ST_WAIT: begin
                    // A response landing with the redirect is the stale one; drop it now.
                    if (Imem_RValid) begin
                        state_d = ST_FETCH;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                ST_HOLD: state_d = ST_FETCH;
                default: state_d = ST_FETCH;
            endcase
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (Imem_Ready) begin
                        pc_d       = pc_plus4;
                        pend_pc4_d = pc_plus4;
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (Imem_RValid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = ST_FETCH;
                        end else if (!Stall) begin
                            deliver = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            buf_d   = Imem_RData;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    deliver_instr = buf_q;
                    if (!Stall) begin
                        deliver = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            pend_pc4_q <= 32'h0000_0000;
            buf_q      <= NOP_INSTR;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc4_q <= pend_pc4_d;
            buf_q      <= buf_d;
            kill_q     <= kill_d;
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk     (clk),
        .reset   (reset),
        .flush_i (Redirect),
        .stall_i (Stall),
        .load_i  (deliver),
        .instr_i (deliver_instr),
        .pc4_i   (pend_pc4_q),
        .instr_o (IFID_Instr),
        .pc4_o   (IFID_PC4),
        .valid_o (IFID_Valid)
    );

    // Reset forces state_q to FETCH, so Req must also be masked while reset is high.
    assign Imem_Req  = (state_q == ST_FETCH) && !Redirect && !reset;
    assign Imem_Addr = pc_q;
    assign PC_Out    = pc_q;

endmodule : instr_fetch_unit

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Directed self-checking bench for instr_fetch_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        Redirect;
    logic [31:0] NextPC;
    logic        Stall;
    logic        Imem_Ready;
    logic        Imem_RValid;
    logic [31:0] Imem_RData;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic [31:0] PC_Out;
    logic [31:0] IFID_Instr;
    logic [31:0] IFID_PC4;
    logic        IFID_Valid;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Redirect    (Redirect),
        .NextPC      (NextPC),
        .Stall       (Stall),
        .Imem_Ready  (Imem_Ready),
        .Imem_RValid (Imem_RValid),
        .Imem_RData  (Imem_RData),
        .Imem_Req    (Imem_Req),
        .Imem_Addr   (Imem_Addr),
        .PC_Out      (PC_Out),
        .IFID_Instr  (IFID_Instr),
        .IFID_PC4    (IFID_PC4),
        .IFID_Valid  (IFID_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs settle here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; Redirect = 1'b0; NextPC = '0; Stall = 1'b0;
        Imem_Ready = 1'b0; Imem_RValid = 1'b0; Imem_RData = '0;

        // 1: reset held three cycles
        step(); step(); step();
        chk("rst_req",   {31'd0, Imem_Req},   32'd0);
        chk("rst_pc",    PC_Out,              32'h0);
        chk("rst_valid", {31'd0, IFID_Valid}, 32'd0);
        chk("rst_instr", IFID_Instr,          32'h0);
        chk("rst_pc4",   IFID_PC4,            32'h0);
        reset = 1'b0; Imem_Ready = 1'b1;
        settle();
        chk("rel_req",  {31'd0, Imem_Req}, 32'd1);
        chk("rel_addr", Imem_Addr,         32'h0);

        // 2: sequential fetch, response one cycle after accept
        step();
        Imem_RValid = 1'b1; Imem_RData = 32'h2000_0001;
        settle();
        chk("seq1_wait_req", {31'd0, Imem_Req}, 32'd0);
        chk("seq1_pc",       PC_Out,            32'h4);
        step();
        Imem_RValid = 1'b0;
        settle();
        chk("seq1_valid", {31'd0, IFID_Valid}, 32'd1);
        chk("seq1_instr", IFID_Instr,          32'h2000_0001);
        chk("seq1_pc4",   IFID_PC4,            32'h4);
        chk("seq1_req",   {31'd0, Imem_Req},   32'd1);
        chk("seq1_addr",  Imem_Addr,           32'h4);
        step();
        Imem_RValid = 1'b1; Imem_RData = 32'h2000_0002;
        settle();
        chk("seq2_bubble", {31'd0, IFID_Valid}, 32'd0);
        chk("seq2_instr0", IFID_Instr,          32'h0);
        step();
        Imem_RValid = 1'b0; Stall = 1'b1;
        settle();
        chk("seq2_valid", {31'd0, IFID_Valid}, 32'd1);
        chk("seq2_instr", IFID_Instr,          32'h2000_0002);
        chk("seq2_pc4",   IFID_PC4,            32'h8);

        // 3: stall while the third response arrives
        step();
        Imem_RValid = 1'b1; Imem_RData = 32'h2000_0003;
        settle();
        chk("stall_hold_pc4",   IFID_PC4,            32'h8);
        chk("stall_hold_valid", {31'd0, IFID_Valid}, 32'd1);
        step();
        Imem_RValid = 1'b0;
        settle();
        chk("hold_instr", IFID_Instr,          32'h2000_0002);
        chk("hold_pc4",   IFID_PC4,            32'h8);
        chk("hold_req",   {31'd0, Imem_Req},   32'd0);
        Stall = 1'b0;
        step();
        chk("unstall_valid", {31'd0, IFID_Valid}, 32'd1);
        chk("unstall_instr", IFID_Instr,          32'h2000_0003);
        chk("unstall_pc4",   IFID_PC4,            32'hC);
        chk("unstall_req",   {31'd0, Imem_Req},   32'd1);
        chk("unstall_addr",  Imem_Addr,           32'hC);

        // 4: redirect while a fetch is outstanding
        step();
        Redirect = 1'b1; NextPC = 32'h0040_0103;
        settle();
        chk("redir_req", {31'd0, Imem_Req}, 32'd0);
        step();
        Redirect = 1'b0;
        settle();
        chk("redir_pc",      PC_Out,            32'h0040_0100);
        chk("redir_waitreq", {31'd0, Imem_Req}, 32'd0);
        step();
        Imem_RValid = 1'b1; Imem_RData = 32'hDEAD_BEEF;
        step();
        Imem_RValid = 1'b0;
        settle();
        chk("kill_valid", {31'd0, IFID_Valid}, 32'd0);
        chk("kill_instr", IFID_Instr,          32'h0);
        chk("kill_req",   {31'd0, Imem_Req},   32'd1);
        chk("kill_addr",  Imem_Addr,           32'h0040_0100);

        // 5: PC+4 wraps to zero
        Redirect = 1'b1; NextPC = 32'hFFFF_FFFC;
        settle();
        chk("wrap_redir_req", {31'd0, Imem_Req}, 32'd0);
        step();
        Redirect = 1'b0;
        settle();
        chk("wrap_addr0", Imem_Addr,         32'hFFFF_FFFC);
        chk("wrap_req0",  {31'd0, Imem_Req}, 32'd1);
        step();
        Imem_RValid = 1'b1; Imem_RData = 32'h2000_000F;
        settle();
        chk("wrap_pc", PC_Out, 32'h0);
        step();
        Imem_RValid = 1'b0;
        settle();
        chk("wrap_valid", {31'd0, IFID_Valid}, 32'd1);
        chk("wrap_instr", IFID_Instr,          32'h2000_000F);
        chk("wrap_pc4",   IFID_PC4,            32'h0);
        chk("wrap_addr",  Imem_Addr,           32'h0);

        // 6: asynchronous reset in the middle of a wait
        step();
        chk("mid_wait_pc", PC_Out, 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("arst_pc",    PC_Out,              32'h0);
        chk("arst_valid", {31'd0, IFID_Valid}, 32'd0);
        chk("arst_req",   {31'd0, Imem_Req},   32'd0);
        step();
        reset = 1'b0; Imem_Ready = 1'b0;
        Imem_RValid = 1'b1; Imem_RData = 32'hBAD0_BAD0;
        settle();
        chk("post_rst_req",  {31'd0, Imem_Req}, 32'd1);
        chk("post_rst_addr", Imem_Addr,         32'h0);
        step();
        Imem_RValid = 1'b0;
        settle();
        chk("stale_valid", {31'd0, IFID_Valid}, 32'd0);
        chk("stale_instr", IFID_Instr,          32'h0);
        chk("stale_req",   {31'd0, Imem_Req},   32'd1);
        chk("stale_pc",    PC_Out,              32'h0);
        Imem_Ready = 1'b1;
        step();
        chk("refetch_pc", PC_Out, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_instr_fetch_unit

`default_nettype wire
